s_counter: RTL and testbench
============================

S_COUNTER -- requirements
Module: s_counter

Interface
REQ-001 The block SHALL have parameter N, default 4, counter width in bits; legal values are N >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-low reset; 0 sampled at a rising clk edge resets the block.
REQ-004 The block SHALL have port pause, input, 1 bit; 1 holds count unchanged.
REQ-005 The block SHALL have port upDown, input, 1 bit, direction select: 1 counts up, 0 counts down.
REQ-006 The block SHALL have port count, output, N bits, current counter value, driven directly from a register.
REQ-007 The block SHALL have port tc, output, 1 bit, terminal-count flag; present only when S_COUNTER_TC_EN is defined (see Configuration).

Function
REQ-008 The counter SHALL update only at a rising clk edge, with no combinational path from any input to count.
REQ-009 With reset=1, pause=0 and upDown=1, count SHALL become (count+1) mod 2^N at each edge.
REQ-010 With reset=1, pause=0 and upDown=0, count SHALL become (count-1) mod 2^N at each edge.
REQ-011 Up-count wrap-around: 2^N-1 SHALL be followed by 0 with no extra cycle or hold.
REQ-012 Down-count wrap-around: 0 SHALL be followed by 2^N-1 with no extra cycle or hold.
REQ-013 With reset=1 and pause=1, count SHALL hold its value for every edge at which pause is sampled 1, regardless of upDown.
REQ-014 On release of pause, counting SHALL resume from the held value at the first edge where pause=0 is sampled; no step is lost or added.
REQ-015 A change of upDown SHALL take effect at the next edge: the next value is the held value +/-1 from the current count, with no reset to 0 or 2^N-1.
REQ-016 Priority at an edge SHALL be reset, then pause, then count.
REQ-017 Counting SHALL have a latency of one clock: the value of upDown sampled at edge k determines count after edge k.

Reset
REQ-018 When reset=0 is sampled at a rising clk edge, count SHALL become 0, including mid-count and while pause=1.
REQ-019 While reset is held at 0, count SHALL remain 0; reset SHALL have no asynchronous effect between edges.
REQ-020 At the first edge with reset=1 after reset, count SHALL become 1 (up) or 2^N-1 (down), or stay 0 if pause=1.
REQ-021 Before the first reset, count SHALL be treated as undefined; a bench SHALL NOT check it.

Configuration
REQ-022 With macro S_COUNTER_TC_EN defined, port tc SHALL exist and be 1 exactly when (upDown=1 and count=2^N-1) or (upDown=0 and count=0).
REQ-023 With S_COUNTER_TC_EN defined, tc SHALL be combinational from registered count and upDown, and SHALL be 0 while reset is being applied only once count=0 and upDown=1.
REQ-024 Without S_COUNTER_TC_EN, port tc and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (N=4, clk period 10)
REQ-025 Hold reset=0 for 2 edges with upDown=1, then release -> count=0 during reset, then 1,2,3,... at successive edges.
REQ-026 Up-count from 0 for 16 edges -> 15 followed by 0; with S_COUNTER_TC_EN, tc=1 only while count=15.
REQ-027 After reset, set upDown=0 -> count sequence 15,14,...,0,15; with S_COUNTER_TC_EN, tc=1 only while count=0.
REQ-028 Up-counting at count=5, assert pause for 1 edge then deassert -> count stays 5 for that edge, then 6.
REQ-029 At count=9, assert reset=0 together with pause=1 for 1 edge -> count=0 at that edge; after release, 1 at the next edge (up).
REQ-030 At count=3, flip upDown from 1 to 0 -> next values 2,1,0,15.

Source files
------------

// File: rtl/s_counter.sv
// N-bit up/down counter with pause and synchronous active-low reset.
// Optional terminal-count output tc is built only when S_COUNTER_TC_EN is defined.
module s_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pause,
  input  logic         upDown,
  output logic [N-1:0] count
`ifdef S_COUNTER_TC_EN
  ,
  output logic         tc
`endif
);

  // Reset wins over pause, and pause wins over counting.
  // Wrap-around in both directions falls out of N-bit modular arithmetic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (pause) begin
      count <= count;
    end else if (upDown) begin
      count <= count + 1'b1;
    end else begin
      count <= count - 1'b1;
    end
  end

`ifdef S_COUNTER_TC_EN
  // Flags the value that the next counting step would wrap from.
  always_comb begin
    tc = 1'b0;
    if (upDown && (count == {N{1'b1}})) begin
      tc = 1'b1;
    end else if (!upDown && (count == '0)) begin
      tc = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_s_counter.sv
// Directed testbench for s_counter (N=4); tc checks are active when
// S_COUNTER_TC_EN is defined for the build.
module tb_s_counter;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic         pause;
  logic         upDown;
  logic [N-1:0] count;
`ifdef S_COUNTER_TC_EN
  logic         tc;
`endif

  int n_checks;
  int n_fail;

  s_counter #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .pause  (pause),
    .upDown (upDown),
    .count  (count)
`ifdef S_COUNTER_TC_EN
    ,
    .tc     (tc)
`endif
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past one rising edge and settle before sampling outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply reset for one edge and leave the counter at 0, idle inputs.
  task automatic apply_reset(input logic dir);
    reset  = 1'b0;
    pause  = 1'b0;
    upDown = dir;
    tick();
    reset  = 1'b1;
  endtask

  task automatic test_reset();
    logic [N-1:0] exp;
    reset  = 1'b0;
    pause  = 1'b0;
    upDown = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (count !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_hold edge %0d: count=%0d expected=0", i, count);
      end
`ifdef S_COUNTER_TC_EN
      n_checks++;
      if (tc !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_tc edge %0d: tc=%b expected=0", i, tc);
      end
`endif
    end
    reset = 1'b1;
    exp = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = exp + 4'd1;
      n_checks++;
      if (count !== exp) begin
        n_fail++;
        $display("FAIL reset_release step %0d: count=%0d expected=%0d", i, count, exp);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [N-1:0] exp;
    apply_reset(1'b1);
    exp = 4'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp = (i == 15) ? 4'd0 : exp + 4'd1;
      n_checks++;
      if (count !== exp) begin
        n_fail++;
        $display("FAIL up_wrap step %0d: count=%0d expected=%0d", i, count, exp);
      end
`ifdef S_COUNTER_TC_EN
      n_checks++;
      if (tc !== (exp == 4'd15)) begin
        n_fail++;
        $display("FAIL up_tc step %0d: tc=%b expected=%b", i, tc, (exp == 4'd15));
      end
`endif
    end
  endtask

  task automatic test_down_wrap();
    logic [N-1:0] exp;
    apply_reset(1'b1);
    upDown = 1'b0;
    exp = 4'd0;
    for (int i = 0; i < 17; i++) begin
      tick();
      exp = (exp == 4'd0) ? 4'd15 : exp - 4'd1;
      n_checks++;
      if (count !== exp) begin
        n_fail++;
        $display("FAIL down_wrap step %0d: count=%0d expected=%0d", i, count, exp);
      end
`ifdef S_COUNTER_TC_EN
      n_checks++;
      if (tc !== (exp == 4'd0)) begin
        n_fail++;
        $display("FAIL down_tc step %0d: tc=%b expected=%b", i, tc, (exp == 4'd0));
      end
`endif
    end
  endtask

  task automatic test_pause();
    apply_reset(1'b1);
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (count !== 4'd5) begin
      n_fail++;
      $display("FAIL pause_setup: count=%0d expected=5", count);
    end
    // Hold across several edges, toggling direction while paused.
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upDown = i[0];
      tick();
      n_checks++;
      if (count !== 4'd5) begin
        n_fail++;
        $display("FAIL pause_hold edge %0d: count=%0d expected=5", i, count);
      end
    end
    upDown = 1'b1;
    pause  = 1'b0;
    tick();
    n_checks++;
    if (count !== 4'd6) begin
      n_fail++;
      $display("FAIL pause_resume: count=%0d expected=6", count);
    end
  endtask

  task automatic test_reset_priority();
    apply_reset(1'b1);
    for (int i = 0; i < 9; i++) tick();
    n_checks++;
    if (count !== 4'd9) begin
      n_fail++;
      $display("FAIL prio_setup: count=%0d expected=9", count);
    end
    reset = 1'b0;
    pause = 1'b1;
    tick();
    n_checks++;
    if (count !== 4'd0) begin
      n_fail++;
      $display("FAIL prio_reset_over_pause: count=%0d expected=0", count);
    end
    reset = 1'b1;
    pause = 1'b0;
    tick();
    n_checks++;
    if (count !== 4'd1) begin
      n_fail++;
      $display("FAIL prio_release: count=%0d expected=1", count);
    end
  endtask

  task automatic test_direction_change();
    logic [N-1:0] exp_seq [4];
    exp_seq[0] = 4'd2;
    exp_seq[1] = 4'd1;
    exp_seq[2] = 4'd0;
    exp_seq[3] = 4'd15;
    apply_reset(1'b1);
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (count !== 4'd3) begin
      n_fail++;
      $display("FAIL dir_setup: count=%0d expected=3", count);
    end
    upDown = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (count !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL dir_change step %0d: count=%0d expected=%0d", i, count, exp_seq[i]);
      end
    end
  endtask

  task automatic test_first_edge_down();
    apply_reset(1'b0);
    tick();
    n_checks++;
    if (count !== 4'd15) begin
      n_fail++;
      $display("FAIL first_edge_down: count=%0d expected=15", count);
    end
    apply_reset(1'b1);
    pause = 1'b1;
    tick();
    n_checks++;
    if (count !== 4'd0) begin
      n_fail++;
      $display("FAIL first_edge_paused: count=%0d expected=0", count);
    end
    pause = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    pause    = 1'b0;
    upDown   = 1'b1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_pause();
    test_reset_priority();
    test_direction_change();
    test_first_edge_down();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
